// File: rtl/int_to_fp32_encoder_if.sv
// Request/response bus of the integer to fp32 encoder.
interface int_to_fp32_encoder_if #(
  parameter int INT_WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [INT_WIDTH-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_data;
  logic                 out_inexact;
  logic                 busy;

  // Producer of integers / consumer of results.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_inexact, busy
  );

  // The encoder itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_inexact, busy
  );
endinterface

// File: rtl/int_to_fp32_encoder.sv
// Multi-cycle integer -> IEEE-754 single encoder. Normalises one leading
// zero per clock, rounds toward zero and flags truncated nonzero bits.
module int_to_fp32_encoder #(
  parameter int INT_WIDTH = 32,
  parameter int SIGNED    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  int_to_fp32_encoder_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, NORM, PACK, HOLD} state_t;

  state_t               state, next_state;
  logic                 sign;
  logic                 zero;
  logic [INT_WIDTH-1:0] mag;
  logic [7:0]           exp;
  logic [31:0]          out_data;
  logic                 out_inexact;
  logic                 neg;
  logic [INT_WIDTH-1:0] abs_in;

  // Magnitude of the incoming operand; the most-negative value maps to
  // 2^(W-1), which is still representable as an unsigned W-bit number.
  assign neg    = (SIGNED != 0) && bus.in_data[INT_WIDTH-1];
  assign abs_in = neg ? (~bus.in_data + 1'b1) : bus.in_data;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (bus.in_valid) next_state = (bus.in_data == '0) ? PACK : NORM;
      NORM: if (mag[INT_WIDTH-1]) next_state = PACK;
      PACK: next_state = HOLD;
      HOLD: if (bus.out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.busy      = (state != IDLE);
    bus.out_valid = (state == HOLD);
  end

  // Datapath: load, shift-normalise, pack the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sign        <= 1'b0;
      zero        <= 1'b0;
      mag         <= '0;
      exp         <= '0;
      out_data    <= '0;
      out_inexact <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          sign <= neg;
          zero <= (bus.in_data == '0);
          mag  <= abs_in;
          exp  <= 8'(127 + INT_WIDTH - 1);
        end
        NORM: if (!mag[INT_WIDTH-1]) begin
          mag <= mag << 1;
          exp <= exp - 8'd1;
        end
        PACK: begin
          if (zero) begin
            out_data    <= '0;
            out_inexact <= 1'b0;
          end else begin
            out_data    <= {sign, exp, mag[INT_WIDTH-2 -: 23]};
            // Bits below the 23-bit fraction; shifting left by 24 leaves
            // only those, and nothing at all when INT_WIDTH is 24.
            out_inexact <= |(mag << 24);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_data    = out_data;
  assign bus.out_inexact = out_inexact;
endmodule

// File: tb/tb_int_to_fp32_encoder.sv
// Directed bench: a signed and an unsigned encoder driven from a vector table
// plus hand-written hold and mid-conversion reset sequences.
module tb_int_to_fp32_encoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int_to_fp32_encoder_if #(.INT_WIDTH(32)) bs ();
  int_to_fp32_encoder_if #(.INT_WIDTH(32)) bu ();

  int_to_fp32_encoder #(.INT_WIDTH(32), .SIGNED(1)) u_s (.clk(clk), .rst_n(rst_n), .bus(bs));
  int_to_fp32_encoder #(.INT_WIDTH(32), .SIGNED(0)) u_u (.clk(clk), .rst_n(rst_n), .bus(bu));

  typedef struct {
    bit          uns;
    logic [31:0] data;
    logic [31:0] exp_data;
    logic        exp_inex;
    int          lat;
  } vec_t;

  vec_t vecs[11];
  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic drive(input bit uns, input logic iv, input logic [31:0] d, input logic ordy);
    if (uns) begin bu.in_valid = iv; bu.in_data = d; bu.out_ready = ordy; end
    else     begin bs.in_valid = iv; bs.in_data = d; bs.out_ready = ordy; end
  endtask

  function automatic logic ov(input bit uns);
    return uns ? bu.out_valid : bs.out_valid;
  endfunction

  // Accept d, count edges until out_valid, check result, then take it.
  task automatic convert(input string name, input bit uns, input logic [31:0] d,
                         input logic [31:0] ed, input logic ei, input int lat);
    int k;
    @(negedge clk);
    check({name, " in_ready idle"}, uns ? bu.in_ready : bs.in_ready, 1);
    drive(uns, 1'b1, d, 1'b0);
    @(posedge clk);               // edge 0: accept
    @(negedge clk);
    drive(uns, 1'b0, '0, 1'b0);
    k = 0;
    while (!ov(uns) && k < 100) begin
      @(posedge clk); k++;
      @(negedge clk);
    end
    if (!ov(uns)) begin
      check({name, " timeout"}, 0, 1);
      return;
    end
    check({name, " latency"}, k, lat);
    check({name, " data"}, uns ? bu.out_data : bs.out_data, ed);
    check({name, " inexact"}, uns ? bu.out_inexact : bs.out_inexact, ei);
    drive(uns, 1'b0, '0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(uns, 1'b0, '0, 1'b0);
    check({name, " valid drop"}, ov(uns), 0);
    check({name, " in_ready back"}, uns ? bu.in_ready : bs.in_ready, 1);
  endtask

  initial begin
    vecs[0]  = '{0, 32'h00000001, 32'h3F800000, 0, 33};
    vecs[1]  = '{0, 32'hFFFFFFF6, 32'hC1200000, 0, 30};
    vecs[2]  = '{0, 32'h0000000F, 32'h41700000, 0, 30};
    vecs[3]  = '{0, 32'h80000000, 32'hCF000000, 0, 2};
    vecs[4]  = '{0, 32'h00000000, 32'h00000000, 0, 1};
    vecs[5]  = '{0, 32'h01000001, 32'h4B800000, 1, 9};
    vecs[6]  = '{1, 32'hFFFFFFFF, 32'h4F7FFFFF, 1, 2};
    vecs[7]  = '{0, 32'h00FFFFFF, 32'h4B7FFFFF, 0, 10};
    vecs[8]  = '{0, 32'h7FFFFFFF, 32'h4EFFFFFF, 1, 3};
    vecs[9]  = '{0, 32'hFFFFFFFF, 32'hBF800000, 0, 33};
    vecs[10] = '{1, 32'h80000000, 32'h4F000000, 0, 2};

    drive(0, 1'b0, '0, 1'b0);
    drive(1, 1'b0, '0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset out_valid", bs.out_valid, 0);
    check("reset out_data", bs.out_data, 0);
    check("reset inexact", bs.out_inexact, 0);
    check("reset busy", bs.busy, 0);
    check("reset in_ready", bs.in_ready, 1);
    rst_n = 1'b1;

    foreach (vecs[i])
      convert($sformatf("vec%0d", i), vecs[i].uns, vecs[i].data,
              vecs[i].exp_data, vecs[i].exp_inex, vecs[i].lat);

    // Result held while the consumer stalls.
    begin
      int k;
      @(negedge clk);
      drive(0, 1'b1, 32'd15, 1'b0);
      @(posedge clk);
      @(negedge clk);
      drive(0, 1'b0, '0, 1'b0);
      k = 0;
      while (!bs.out_valid && k < 100) begin @(posedge clk); k++; @(negedge clk); end
      check("hold reached", bs.out_valid, 1);
      for (int c = 0; c < 5; c++) begin
        check("hold valid", bs.out_valid, 1);
        check("hold data", bs.out_data, 32'h41700000);
        check("hold in_ready", bs.in_ready, 0);
        check("hold busy", bs.busy, 1);
        @(posedge clk); @(negedge clk);
      end
      drive(0, 1'b0, '0, 1'b1);
      @(posedge clk); @(negedge clk);
      drive(0, 1'b0, '0, 1'b0);
      check("pulse valid drop", bs.out_valid, 0);
    end

    // Back-to-back requests come out in order.
    convert("b2b0", 0, 32'hFFFFFFF6, 32'hC1200000, 0, 30);
    convert("b2b1", 0, 32'h00000001, 32'h3F800000, 0, 33);

    // Reset mid-normalisation discards the conversion.
    @(negedge clk);
    drive(0, 1'b1, 32'd1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, '0, 1'b0);
    repeat (10) begin @(posedge clk); @(negedge clk); end
    check("mid busy", bs.busy, 1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst busy", bs.busy, 0);
    check("rst in_ready", bs.in_ready, 1);
    check("rst out_valid", bs.out_valid, 0);
    begin
      bit seen = 0;
      repeat (40) begin
        @(posedge clk); @(negedge clk);
        if (bs.out_valid) seen = 1;
      end
      check("rst no output", seen, 0);
    end
    convert("post rst", 0, 32'h00000001, 32'h3F800000, 0, 33);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
